// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph constants and cathode polarity.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD/hex to 7-segment decoder (active-low cathodes).
// Codes 10-15 render as a dash unless hex_mode selects A b C d E F.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
      4'hF:    seg = hex_mode ? SEG_F : SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input snapshot,
// PWM brightness, one dead cycle per slot and registered outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HEX_MODE    = 0,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int unsigned CntW     = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW     = $clog2(N_DIGITS);
  localparam int unsigned SliceLen = REFRESH_DIV >> BRIGHT_W;
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(N_DIGITS - 1);
  localparam logic            HexMode = (HEX_MODE != 0);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [N_DIGITS-1:0]     snap_blank_q, snap_blank_d;
  logic [BRIGHT_W-1:0]     snap_bright_q, snap_bright_d;
  logic                    wrap_q, wrap_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic                    frame_end;
  logic                    lit;
  logic [CntW-1:0]         level;
  logic [3:0]              code;
  logic [6:0]              glyph;

  seg_decoder u_dec (
    .code     (code),
    .hex_mode (HexMode),
    .seg      (glyph)
  );

  always_comb begin
    frame_end = (cnt_q == CntMax) && (idx_q == IdxMax);

    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    snap_bright_d = snap_bright_q;
    if (frame_end) begin
      snap_digits_d = digits;
      snap_dp_d     = dp_mask;
      snap_blank_d  = blank_mask;
      snap_bright_d = brightness;
    end

    // wrap_q delays the tick so it lines up with the registered idx-0 dead cycle.
    wrap_d = frame_end;
    tick_d = wrap_q;

    code = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) code = snap_digits_q[4*k +: 4];
    end

    level = cnt_q / CntW'(SliceLen);
    lit   = (cnt_q != '0) && !snap_blank_q[idx_q] && (level <= CntW'(snap_bright_q));

    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = SEG_OFF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      dp_d        = snap_dp_q[idx_q] ? SEG_ON : SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '1;
      snap_bright_q <= '0;
      wrap_q        <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= SEG_OFF;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      snap_bright_q <= snap_bright_d;
      wrap_q        <= wrap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      tick_q        <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected outputs queued per cycle by the stimulus,
// popped and compared by a negedge monitor; two DUTs cover HEX_MODE 0 and 1.
module tb_seg_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned BW = 2;
  localparam int FRAME = N * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } out_t;

  typedef struct {
    out_t h0;
    out_t h1;
    int   frame;
    int   pos;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    blank_mask = '0;
  logic [1:0]    brightness = '0;
  logic [3:0]    an0, an1;
  logic [6:0]    seg0, seg1;
  logic          dp0, dp1, ft0, ft1;

  logic [15:0]   cfg_dig    [0:9];
  logic [3:0]    cfg_dp     [0:9];
  logic [3:0]    cfg_blank  [0:9];
  logic [1:0]    cfg_bright [0:9];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(0), .BRIGHT_W(BW)) dut0 (
    .clk(clk), .reset_(reset_), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .brightness(brightness), .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
  );

  seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .BRIGHT_W(BW)) dut1 (
    .clk(clk), .reset_(reset_), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .brightness(brightness), .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] code, input bit hex);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return hex ? 7'b0001000 : 7'b0111111;
      4'hB: return hex ? 7'b0000011 : 7'b0111111;
      4'hC: return hex ? 7'b1000110 : 7'b0111111;
      4'hD: return hex ? 7'b0100001 : 7'b0111111;
      4'hE: return hex ? 7'b0000110 : 7'b0111111;
      default: return hex ? 7'b0001110 : 7'b0111111;
    endcase
  endfunction

  // Expected outputs for frame f (0 = dark post-reset frame), counter position pos.
  function automatic out_t model(input int f, input int pos, input bit hex);
    logic [15:0] dg;
    logic [3:0]  dpm, bl;
    logic [1:0]  br;
    int          k, c;
    out_t        o;
    if (f == 0) begin
      dg = '0; dpm = '0; bl = 4'hF; br = '0;
    end else begin
      dg = cfg_dig[f]; dpm = cfg_dp[f]; bl = cfg_blank[f]; br = cfg_bright[f];
    end
    k = pos / RD;
    c = pos % RD;
    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.ft  = (f >= 1) && (pos == 0);
    if (c != 0 && !bl[k] && (c / 4) <= int'(br)) begin
      o.an[k] = 1'b0;
      o.seg   = ref_glyph(dg[4*k +: 4], hex);
      o.dp    = ~dpm[k];
    end
    return o;
  endfunction

  task automatic check_out(input string name, input int f, input int pos,
                           input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s frame %0d pos %0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                  name, f, pos, act.an, act.seg, act.dp, act.ft, exp.an, exp.seg, exp.dp, exp.ft);
  endtask

  task automatic drive_in(input int f);
    digits     = cfg_dig[f];
    dp_mask    = cfg_dp[f];
    blank_mask = cfg_blank[f];
    brightness = cfg_bright[f];
  endtask

  // Inputs for frame d+1 change mid slot 1 of frame d; the snapshot must hide that.
  task automatic run(input int total);
    for (int n = 1; n <= total; n++) begin
      int   d, pos;
      exp_t e;
      d   = (n - 1) / FRAME;
      pos = (n - 1) % FRAME;
      if (pos == 20) drive_in(d + 1);
      @(posedge clk);
      #1;
      e.h0    = model(d, pos, 1'b0);
      e.h1    = model(d, pos, 1'b1);
      e.frame = d;
      e.pos   = pos;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_out("scan_hex0", e.frame, e.pos, {an0, seg0, dp0, ft0}, e.h0);
      check_out("scan_hex1", e.frame, e.pos, {an1, seg1, dp1, ft1}, e.h1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, checks=%0d passed=%0d",
             n_checks, n_pass);
    $fatal(1);
  end

  initial begin
    out_t rst_exp;
    rst_exp = {4'hF, 7'h7F, 1'b1, 1'b0};

    cfg_dig[0] = 16'h0000; cfg_dp[0] = 4'b0000; cfg_blank[0] = 4'b1111; cfg_bright[0] = 2'd0;
    cfg_dig[1] = 16'h3210; cfg_dp[1] = 4'b0100; cfg_blank[1] = 4'b0000; cfg_bright[1] = 2'd3;
    cfg_dig[2] = 16'hFA5B; cfg_dp[2] = 4'b0000; cfg_blank[2] = 4'b0000; cfg_bright[2] = 2'd3;
    cfg_dig[3] = 16'h1234; cfg_dp[3] = 4'b0001; cfg_blank[3] = 4'b0000; cfg_bright[3] = 2'd1;
    cfg_dig[4] = 16'h1234; cfg_dp[4] = 4'b0000; cfg_blank[4] = 4'b0000; cfg_bright[4] = 2'd0;
    cfg_dig[5] = 16'h1234; cfg_dp[5] = 4'b0010; cfg_blank[5] = 4'b0000; cfg_bright[5] = 2'd3;
    cfg_dig[6] = 16'h5678; cfg_dp[6] = 4'b1000; cfg_blank[6] = 4'b0100; cfg_bright[6] = 2'd3;
    cfg_dig[7] = 16'h9CE8; cfg_dp[7] = 4'b1111; cfg_blank[7] = 4'b1001; cfg_bright[7] = 2'd2;
    cfg_dig[8] = 16'h3210; cfg_dp[8] = 4'b0000; cfg_blank[8] = 4'b0000; cfg_bright[8] = 2'd3;
    cfg_dig[9] = 16'h0000; cfg_dp[9] = 4'b0000; cfg_blank[9] = 4'b1111; cfg_bright[9] = 2'd0;

    drive_in(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_ = 1'b1;

    // Frames 1..7 exercise scan, glyphs, PWM, tear-free update, blanking; stop mid slot 2.
    run(8 * FRAME + 41);

    @(negedge clk);
    #2 reset_ = 1'b0;
    #1;
    check_out("async_reset_hex0", 8, 40, {an0, seg0, dp0, ft0}, rst_exp);
    check_out("async_reset_hex1", 8, 40, {an1, seg1, dp1, ft1}, rst_exp);
    repeat (2) @(posedge clk);
    @(negedge clk);

    cfg_dig[1] = 16'h0987; cfg_dp[1] = 4'b0011; cfg_blank[1] = 4'b0000; cfg_bright[1] = 2'd3;
    cfg_dig[2] = 16'hDDDD; cfg_dp[2] = 4'b0000; cfg_blank[2] = 4'b0010; cfg_bright[2] = 2'd1;
    #2 reset_ = 1'b1;

    // Dark restart frame, then the first tick exactly one frame after release.
    run(2 * FRAME + 2);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
